// File: rtl/csr_reg.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause/mip plus a
// 64-bit cycle counter. Handles trap entry and mret, with bypassing on both
// the read path and the mepc/mtvec forwarding paths.
module csr_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [11:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [11:0] raddr_i,
   output logic [31:0] rdata_o,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] epc_i,
   input  logic        timer_irq_i,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mtvec_o,
   output logic        int_req_o
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;

   // Bits a software write can change; mip and unknown addresses have none.
   function automatic logic [31:0] write_mask(input logic [11:0] addr);
      logic [31:0] m;
      case (addr)
         A_MSTATUS:  m = 32'h0000_0088;
         A_MIE:      m = 32'h0000_0080;
         A_MTVEC,
         A_MSCRATCH,
         A_MEPC,
         A_MCAUSE,
         A_MCYCLE,
         A_MCYCLEH:  m = 32'hFFFF_FFFF;
         default:    m = 32'h0000_0000;
      endcase
      return m;
   endfunction

   logic        mie_r;        // mstatus.MIE
   logic        mpie_r;       // mstatus.MPIE
   logic        mtie_r;       // mie.MTIE
   logic        mtip_r;       // mip.MTIP
   logic [31:0] mtvec_r;
   logic [31:0] mscratch_r;
   logic [31:0] mepc_r;
   logic [31:0] mcause_r;
   logic [63:0] mcycle_r;

   logic        mie_s;
   logic        mpie_s;
   logic        mtie_s;
   logic [31:0] mtvec_s;
   logic [31:0] mscratch_s;
   logic [31:0] mepc_s;
   logic [31:0] mcause_s;
   logic [63:0] mcycle_s;
   logic        trap_s;
   logic        mret_s;
   logic [31:0] stored_s;

   // Decode the committed exception code into trap entry / mret.
   always_comb begin
      trap_s = 1'b0;
      mret_s = 1'b0;
      case (excepttype_i)
         32'h0000_0001,
         32'h0000_0008,
         32'h0000_000A: trap_s = 1'b1;
         32'h0000_000E: mret_s = 1'b1;
         default: begin
            trap_s = 1'b0;
            mret_s = 1'b0;
         end
      endcase
   end

   // Next-state: software writes first, then trap/mret overrides the
   // registers they own (mstatus, mepc, mcause).
   always_comb begin
      mie_s      = mie_r;
      mpie_s     = mpie_r;
      mtie_s     = mtie_r;
      mtvec_s    = mtvec_r;
      mscratch_s = mscratch_r;
      mepc_s     = mepc_r;
      mcause_s   = mcause_r;
      mcycle_s   = mcycle_r + 64'd1;
      if (we_i) begin
         case (waddr_i)
            A_MSTATUS: begin
               mie_s  = wdata_i[3];
               mpie_s = wdata_i[7];
            end
            A_MIE:      mtie_s     = wdata_i[7];
            A_MTVEC:    mtvec_s    = wdata_i;
            A_MSCRATCH: mscratch_s = wdata_i;
            A_MEPC:     mepc_s     = wdata_i;
            A_MCAUSE:   mcause_s   = wdata_i;
            A_MCYCLE:   mcycle_s   = {mcycle_r[63:32], wdata_i};
            A_MCYCLEH:  mcycle_s   = {wdata_i, mcycle_r[31:0]};
            default:    mtvec_s    = mtvec_r;
         endcase
      end else begin
         mtvec_s = mtvec_r;
      end
      if (trap_s) begin
         mepc_s = epc_i;
         mpie_s = mie_r;
         mie_s  = 1'b0;
         case (excepttype_i)
            32'h0000_0001: mcause_s = 32'h8000_0007;
            32'h0000_0008: mcause_s = 32'h0000_000B;
            default:       mcause_s = 32'h0000_0002;
         endcase
      end else if (mret_s) begin
         mepc_s   = mepc_r;
         mcause_s = mcause_r;
         mie_s    = mpie_r;
         mpie_s   = 1'b1;
      end else begin
         mepc_s = mepc_s;
      end
   end

   // State registers; reset clears everything including the counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mie_r      <= 1'b0;
         mpie_r     <= 1'b0;
         mtie_r     <= 1'b0;
         mtip_r     <= 1'b0;
         mtvec_r    <= 32'h0000_0000;
         mscratch_r <= 32'h0000_0000;
         mepc_r     <= 32'h0000_0000;
         mcause_r   <= 32'h0000_0000;
         mcycle_r   <= 64'h0000_0000_0000_0000;
      end else begin
         mie_r      <= mie_s;
         mpie_r     <= mpie_s;
         mtie_r     <= mtie_s;
         mtip_r     <= timer_irq_i;
         mtvec_r    <= mtvec_s;
         mscratch_r <= mscratch_s;
         mepc_r     <= mepc_s;
         mcause_r   <= mcause_s;
         mcycle_r   <= mcycle_s;
      end
   end

   // Stored value of the CSR at the read address.
   always_comb begin
      case (raddr_i)
         A_MSTATUS:  stored_s = {24'h00_0000, mpie_r, 3'b000, mie_r, 3'b000};
         A_MIE:      stored_s = {24'h00_0000, mtie_r, 7'b000_0000};
         A_MTVEC:    stored_s = mtvec_r;
         A_MSCRATCH: stored_s = mscratch_r;
         A_MEPC:     stored_s = mepc_r;
         A_MCAUSE:   stored_s = mcause_r;
         A_MIP:      stored_s = {24'h00_0000, mtip_r, 7'b000_0000};
         A_MCYCLE:   stored_s = mcycle_r[31:0];
         A_MCYCLEH:  stored_s = mcycle_r[63:32];
         default:    stored_s = 32'h0000_0000;
      endcase
   end

   // Combinational outputs with same-cycle write bypass, forced low in reset.
   always_comb begin
      rdata_o     = 32'h0000_0000;
      csr_mepc_o  = 32'h0000_0000;
      csr_mtvec_o = 32'h0000_0000;
      int_req_o   = 1'b0;
      if (rst) begin
         if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i & write_mask(waddr_i);
         end else begin
            rdata_o = stored_s;
         end
         csr_mepc_o  = (we_i && (waddr_i == A_MEPC))  ? wdata_i : mepc_r;
         csr_mtvec_o = (we_i && (waddr_i == A_MTVEC)) ? wdata_i : mtvec_r;
         int_req_o   = mie_r & mtie_r & mtip_r;
      end else begin
         int_req_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_csr_reg.sv
// Randomized scoreboard bench for csr_reg: the driver predicts each cycle's
// outputs from a reference model and queues them; a negedge monitor checks.
module tb_csr_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we_i = 1'b0;
   logic [11:0] waddr_i = 12'h000;
   logic [31:0] wdata_i = 32'h0;
   logic [11:0] raddr_i = 12'h000;
   logic [31:0] rdata_o;
   logic [31:0] excepttype_i = 32'h0;
   logic [31:0] epc_i = 32'h0;
   logic        timer_irq_i = 1'b0;
   logic [31:0] csr_mepc_o;
   logic [31:0] csr_mtvec_o;
   logic        int_req_o;

   csr_reg dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .raddr_i(raddr_i), .rdata_o(rdata_o), .excepttype_i(excepttype_i),
      .epc_i(epc_i), .timer_irq_i(timer_irq_i), .csr_mepc_o(csr_mepc_o),
      .csr_mtvec_o(csr_mtvec_o), .int_req_o(int_req_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] mepc;
      logic [31:0] mtvec;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: CSRs held as whole architectural words.
   logic [31:0] m_status, m_ie, m_tvec, m_scratch, m_epc, m_cause, m_ip;
   logic [63:0] m_cycle;

   function automatic logic [31:0] wmask(input logic [11:0] a);
      case (a)
         12'h300: return 32'h0000_0088;
         12'h304: return 32'h0000_0080;
         12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80: return 32'hFFFF_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mread(input logic [11:0] a);
      case (a)
         12'h300: return m_status;
         12'h304: return m_ie;
         12'h305: return m_tvec;
         12'h340: return m_scratch;
         12'h341: return m_epc;
         12'h342: return m_cause;
         12'h344: return m_ip;
         12'hB00: return m_cycle[31:0];
         12'hB80: return m_cycle[63:32];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_clear();
      m_status = 0; m_ie = 0; m_tvec = 0; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_ip = 0; m_cycle = 0;
   endtask

   // One clock cycle of stimulus: drive, predict, queue, advance the model.
   task automatic cyc(input bit we, input logic [11:0] wa, input logic [31:0] wd,
                      input logic [11:0] ra, input logic [31:0] ex,
                      input logic [31:0] ep, input bit irq, input bit rv);
      exp_t e;
      bit   trap, mret;
      logic [31:0] old_status;
      we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra;
      excepttype_i = ex; epc_i = ep; timer_irq_i = irq; rst = rv;
      if (!rv) begin
         model_clear();
         e.rdata = 0; e.mepc = 0; e.mtvec = 0; e.irq = 0;
         exp_q.push_back(e);
      end else begin
         e.rdata = (we && wa == ra) ? (wd & wmask(wa)) : mread(ra);
         e.mepc  = (we && wa == 12'h341) ? wd : m_epc;
         e.mtvec = (we && wa == 12'h305) ? wd : m_tvec;
         e.irq   = m_status[3] && m_ie[7] && m_ip[7];
         exp_q.push_back(e);
         trap = (ex == 32'h1) || (ex == 32'h8) || (ex == 32'hA);
         mret = (ex == 32'hE);
         old_status = m_status;
         m_ip = irq ? 32'h80 : 32'h0;
         if (we && wa == 12'hB00)      m_cycle = {m_cycle[63:32], wd};
         else if (we && wa == 12'hB80) m_cycle = {wd, m_cycle[31:0]};
         else                          m_cycle = m_cycle + 64'd1;
         if (we) begin
            case (wa)
               12'h300: if (!(trap || mret)) m_status = wd & 32'h88;
               12'h304: m_ie = wd & 32'h80;
               12'h305: m_tvec = wd;
               12'h340: m_scratch = wd;
               12'h341: if (!(trap || mret)) m_epc = wd;
               12'h342: if (!(trap || mret)) m_cause = wd;
               default: ;
            endcase
         end
         if (trap) begin
            m_epc = ep;
            m_status = old_status[3] ? 32'h80 : 32'h0;
            m_cause = (ex == 32'h1) ? 32'h8000_0007 : (ex == 32'h8) ? 32'hB : 32'h2;
         end else if (mret) begin
            m_status = 32'h80 | (old_status[7] ? 32'h08 : 32'h0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle with a pending prediction, compare all outputs.
   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("rdata", rdata_o, mon_e.rdata);
         chk("mepc_fwd", csr_mepc_o, mon_e.mepc);
         chk("mtvec_fwd", csr_mtvec_o, mon_e.mtvec);
         chk("int_req", {31'b0, int_req_o}, {31'b0, mon_e.irq});
      end
   end

   logic [11:0] waddr_pool [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'hB00, 12'hB80, 12'h123, 12'hFFF};
   logic [11:0] raddr_pool [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h344, 12'hB00, 12'hB80, 12'h123, 12'hFFF};
   logic [31:0] exc_pool [10]   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1,
                                    32'h8, 32'hA, 32'hE, 32'h3, 32'h10};

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      // Reset held with a bypassing write present: everything must read 0.
      cyc(1, 12'h305, 32'hDEAD_BEEF, 12'h305, 0, 0, 1, 0);
      cyc(1, 12'h341, 32'h1234_5678, 12'h341, 0, 0, 0, 0);
      // First cycles after release: mcycle reads 0 then 1.
      cyc(0, 0, 0, 12'hB00, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'hB00, 0, 0, 0, 1);
      // mtvec write with forwarding, then read back.
      cyc(1, 12'h305, 32'h100, 12'h305, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'h305, 0, 0, 0, 1);
      // mstatus masking.
      cyc(1, 12'h300, 32'hFFFF_FFFF, 12'h344, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'h300, 0, 0, 0, 1);
      // Enable timer interrupt, raise irq.
      cyc(1, 12'h304, 32'hFFFF_FFFF, 12'h304, 0, 0, 1, 1);
      cyc(0, 0, 0, 12'h344, 0, 0, 1, 1);
      cyc(0, 0, 0, 12'h344, 0, 0, 1, 1);
      // Interrupt trap entry.
      cyc(0, 0, 0, 12'h341, 32'h1, 32'h44, 1, 1);
      cyc(0, 0, 0, 12'h342, 0, 0, 1, 1);
      cyc(0, 0, 0, 12'h300, 0, 0, 1, 1);
      // mret, then ecall overriding a same-cycle mepc write.
      cyc(0, 0, 0, 12'h300, 32'hE, 0, 0, 1);
      cyc(0, 0, 0, 12'h300, 0, 0, 0, 1);
      cyc(1, 12'h341, 32'h200, 12'h341, 32'h8, 32'h10, 0, 1);
      cyc(0, 0, 0, 12'h341, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'h342, 0, 0, 0, 1);
      // Held illegal-instruction code applies every cycle.
      cyc(0, 0, 0, 12'h300, 32'hA, 32'h20, 0, 1);
      cyc(0, 0, 0, 12'h341, 32'hA, 32'h24, 0, 1);
      cyc(0, 0, 0, 12'h342, 32'hA, 32'h28, 0, 1);
      // Counter wrap.
      cyc(1, 12'hB00, 32'hFFFF_FFFF, 12'hB00, 0, 0, 0, 1);
      cyc(1, 12'hB80, 32'hFFFF_FFFF, 12'hB80, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'hB00, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'hB80, 0, 0, 0, 1);
      // Reset during a trap discards it.
      cyc(1, 12'h340, 32'h5A5A_5A5A, 12'h340, 32'h1, 32'h99, 1, 1);
      cyc(0, 0, 0, 12'h341, 32'h1, 32'h99, 1, 0);
      cyc(0, 0, 0, 12'h341, 0, 0, 0, 1);
      cyc(0, 0, 0, 12'h340, 0, 0, 0, 1);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 2) != 0),
             waddr_pool[$urandom_range(0, 9)],
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
             raddr_pool[$urandom_range(0, 10)],
             exc_pool[$urandom_range(0, 9)],
             $urandom,
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 99) != 0));
      end
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
